// File: rtl/light_updown_counter.sv
// Bounded up/down counter driven by two asynchronous flags.
// Each flag is synchronised, debounced and optionally edge-detected before stepping the count.
module light_updown_counter #(
  parameter int WIDTH      = 4,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 15,
  parameter int STEP       = 1,
  parameter int WRAP       = 1,
  parameter int EDGE_MODE  = 1,
  parameter int DEB_CYCLES = 1
) (
  input  logic             FPGA_CLK,
  input  logic             FPGA_RST_N,
  input  logic             flag_light_1,
  input  logic             flag_light_2,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Num_of_bit,
  output logic             at_max,
  output logic             at_min,
  output logic             limit_hit
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]    ONE_C    = 1;
  localparam logic [WIDTH:0]   MIN_E    = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_E    = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_E   = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   ONE_E    = 1;
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    filt;
  logic [1:0]    filt_d;
  logic [CW-1:0] deb_cnt [2];
  logic          up_ev;
  logic          dn_ev;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             hit_q;
  logic             hit_d;

  logic [WIDTH:0]   cnt_e;
  logic [WIDTH:0]   lv_e;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   floor_dn;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] diff_dn;
  logic [WIDTH-1:0] wrap_dn;

  assign raw = {flag_light_2, flag_light_1};

  // Index 0 is the up flag, index 1 the down flag; a partial debounce count is lost on reset.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      s1     <= '0;
      s2     <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + ONE_C;
        end
      end
    end
  end

  assign up_ev = (EDGE_MODE != 0) ? (filt[0] & ~filt_d[0]) : filt[0];
  assign dn_ev = (EDGE_MODE != 0) ? (filt[1] & ~filt_d[1]) : filt[1];

  // Next count: load beats events, opposing events cancel, otherwise step with wrap or clip.
  always_comb begin
    cnt_e    = {1'b0, count_q};
    lv_e     = {1'b0, load_val};
    sum_up   = cnt_e + STEP_E;
    floor_dn = MIN_E + STEP_E;
    wrap_up  = WIDTH'(MIN_E + (sum_up - MAX_E - ONE_E));
    diff_dn  = WIDTH'(cnt_e - STEP_E);
    wrap_dn  = WIDTH'(MAX_E - (floor_dn - cnt_e - ONE_E));
    count_d  = count_q;
    hit_d    = 1'b0;

    if (load) begin
      // Offset by one so the lower-bound test still means something when MIN_VAL is zero.
      if (lv_e > MAX_E)
        count_d = MAX_W;
      else if (lv_e + ONE_E > MIN_E)
        count_d = load_val;
      else
        count_d = MIN_W;
    end else if (up_ev && !dn_ev) begin
      if (sum_up <= MAX_E) begin
        count_d = sum_up[WIDTH-1:0];
      end else if (WRAP != 0) begin
        count_d = wrap_up;
        hit_d   = 1'b1;
      end else begin
        count_d = MAX_W;
        hit_d   = (count_q != MAX_W);
      end
    end else if (dn_ev && !up_ev) begin
      if (cnt_e >= floor_dn) begin
        count_d = diff_dn;
      end else if (WRAP != 0) begin
        count_d = wrap_dn;
        hit_d   = 1'b1;
      end else begin
        count_d = MIN_W;
        hit_d   = (count_q != MIN_W);
      end
    end
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      count_q <= MIN_W;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign Num_of_bit = count_q;
  assign at_max     = (count_q == MAX_W);
  assign at_min     = (count_q == MIN_W);
  assign limit_hit  = hit_q;

endmodule

// File: tb/tb_light_updown_counter.sv
// Self-checking bench for light_updown_counter: four parameterisations share clock and reset,
// expectations go through a scoreboard queue and are compared one edge-settle after each update.
module tb_light_updown_counter;

  typedef enum {OP_LOAD, OP_UP, OP_DN, OP_BOTH, OP_LOAD_UP} op_e;

  typedef struct {
    op_e   op;
    int    val;
    int    cnt;
    bit    mx;
    bit    mn;
    bit    hit;
    string name;
  } vec_t;

  typedef struct {
    string name;
    int    dut;
    int    cnt;
    bit    mx;
    bit    mn;
    bit    hit;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     up;
  logic [3:0]     dn;
  logic [3:0]     ld;
  logic [3:0][4:0] lv;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic [4:0] cnt_e;
  logic       mx_a, mx_b, mx_c, mx_e;
  logic       mn_a, mn_b, mn_c, mn_e;
  logic       hit_a, hit_b, hit_c, hit_e;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  light_updown_counter dut_a (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n), .flag_light_1(up[0]), .flag_light_2(dn[0]),
    .load(ld[0]), .load_val(lv[0][3:0]), .Num_of_bit(cnt_a), .at_max(mx_a), .at_min(mn_a),
    .limit_hit(hit_a));

  light_updown_counter #(.MAX_VAL(10), .STEP(4), .WRAP(0)) dut_b (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n), .flag_light_1(up[1]), .flag_light_2(dn[1]),
    .load(ld[1]), .load_val(lv[1][3:0]), .Num_of_bit(cnt_b), .at_max(mx_b), .at_min(mn_b),
    .limit_hit(hit_b));

  light_updown_counter #(.DEB_CYCLES(4)) dut_c (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n), .flag_light_1(up[2]), .flag_light_2(dn[2]),
    .load(ld[2]), .load_val(lv[2][3:0]), .Num_of_bit(cnt_c), .at_max(mx_c), .at_min(mn_c),
    .limit_hit(hit_c));

  light_updown_counter #(.WIDTH(5), .MAX_VAL(15), .EDGE_MODE(0)) dut_e (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n), .flag_light_1(up[3]), .flag_light_2(dn[3]),
    .load(ld[3]), .load_val(lv[3]), .Num_of_bit(cnt_e), .at_max(mx_e), .at_min(mn_e),
    .limit_hit(hit_e));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic get_out(input int d, output int c, output bit mx, output bit mn, output bit h);
    case (d)
      0:       begin c = int'(cnt_a); mx = mx_a; mn = mn_a; h = hit_a; end
      1:       begin c = int'(cnt_b); mx = mx_b; mn = mn_b; h = hit_b; end
      2:       begin c = int'(cnt_c); mx = mx_c; mn = mn_c; h = hit_c; end
      default: begin c = int'(cnt_e); mx = mx_e; mn = mn_e; h = hit_e; end
    endcase
  endtask

  task automatic check_field(input string n, input string f, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", n, f, act, req);
    end
  endtask

  task automatic expect_out(input string n, input int d, input int c, input bit mx,
                            input bit mn, input bit h);
    exp_t e;
    e.name = n; e.dut = d; e.cnt = c; e.mx = mx; e.mn = mn; e.hit = h;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    int   c;
    bit   mx, mn, h;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
      return;
    end
    e = sb.pop_front();
    get_out(e.dut, c, mx, mn, h);
    check_field(e.name, "count", c, e.cnt);
    check_field(e.name, "at_max", int'(mx), int'(e.mx));
    check_field(e.name, "at_min", int'(mn), int'(e.mn));
    check_field(e.name, "limit_hit", int'(h), int'(e.hit));
  endtask

  task automatic do_load(input int d, input int v);
    ld[d] = 1'b1;
    lv[d] = 5'(v);
    tick(1);
    ld[d] = 1'b0;
  endtask

  // Raises the flags and lands just after the edge where a default-debounce DUT steps.
  task automatic pulse(input int d, input bit u, input bit w);
    up[d] = u;
    dn[d] = w;
    tick(4);
  endtask

  task automatic release_flags(input int d);
    up[d] = 1'b0;
    dn[d] = 1'b0;
    tick(5);
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.op)
      OP_LOAD: begin
        do_load(0, v.val);
        expect_out(v.name, 0, v.cnt, v.mx, v.mn, v.hit);
        checkOutput();
      end
      OP_LOAD_UP: begin
        up[0] = 1'b1;
        tick(3);
        ld[0] = 1'b1;
        lv[0] = 5'(v.val);
        tick(1);
        ld[0] = 1'b0;
        expect_out(v.name, 0, v.cnt, v.mx, v.mn, v.hit);
        checkOutput();
        tick(1);
        expect_out({v.name, "_next"}, 0, v.cnt, v.mx, v.mn, 1'b0);
        checkOutput();
        release_flags(0);
      end
      default: begin
        pulse(0, v.op != OP_DN, v.op != OP_UP);
        expect_out(v.name, 0, v.cnt, v.mx, v.mn, v.hit);
        checkOutput();
        release_flags(0);
      end
    endcase
  endtask

  initial begin
    vecs[0] = '{OP_DN,      0, 15, 1'b1, 1'b0, 1'b1, "tbl_dn_wrap"};
    vecs[1] = '{OP_UP,      0,  0, 1'b0, 1'b1, 1'b1, "tbl_up_wrap"};
    vecs[2] = '{OP_UP,      0,  1, 1'b0, 1'b0, 1'b0, "tbl_up"};
    vecs[3] = '{OP_LOAD,   14, 14, 1'b0, 1'b0, 1'b0, "tbl_load14"};
    vecs[4] = '{OP_UP,      0, 15, 1'b1, 1'b0, 1'b0, "tbl_up_to_max"};
    vecs[5] = '{OP_BOTH,    0, 15, 1'b1, 1'b0, 1'b0, "tbl_both"};
    vecs[6] = '{OP_LOAD_UP, 5,  5, 1'b0, 1'b0, 1'b0, "tbl_load_up"};
    vecs[7] = '{OP_DN,      0,  4, 1'b0, 1'b0, 1'b0, "tbl_dn"};
    vecs[8] = '{OP_LOAD,    0,  0, 1'b0, 1'b1, 1'b0, "tbl_load0"};
    vecs[9] = '{OP_UP,      0,  1, 1'b0, 1'b0, 1'b0, "tbl_up_again"};

    up = '0; dn = '0; ld = '0; lv = '0;
    rst_n = 1'b0;
    tick(2);
    for (int d = 0; d < 4; d++) begin
      expect_out($sformatf("reset_dut%0d", d), d, 0, 1'b0, 1'b1, 1'b0);
      checkOutput();
    end
    rst_n = 1'b1;

    $display("[TB] held up flag steps once");
    up[0] = 1'b1;
    tick(3);
    expect_out("hold_edge3", 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    tick(1);
    expect_out("hold_edge4", 0, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick(6);
    expect_out("hold_edge10", 0, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    release_flags(0);
    pulse(0, 1'b1, 1'b0);
    expect_out("second_pulse", 0, 2, 1'b0, 1'b0, 1'b0);
    checkOutput();
    release_flags(0);

    $display("[TB] count to max and wrap");
    do_load(0, 0);
    for (int i = 1; i <= 15; i++) begin
      pulse(0, 1'b1, 1'b0);
      expect_out($sformatf("climb_%0d", i), 0, i, i == 15, 1'b0, 1'b0);
      checkOutput();
      release_flags(0);
    end
    pulse(0, 1'b1, 1'b0);
    expect_out("wrap_to_min", 0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput();
    up[0] = 1'b0;
    tick(1);
    expect_out("hit_one_cycle", 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    tick(4);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] saturate with step 4");
    do_load(1, 8);
    expect_out("sat_load8", 1, 8, 1'b0, 1'b0, 1'b0);
    checkOutput();
    pulse(1, 1'b1, 1'b0);
    expect_out("sat_up_clip", 1, 10, 1'b1, 1'b0, 1'b1);
    checkOutput();
    release_flags(1);
    pulse(1, 1'b1, 1'b0);
    expect_out("sat_up_at_max", 1, 10, 1'b1, 1'b0, 1'b0);
    checkOutput();
    release_flags(1);
    do_load(1, 2);
    pulse(1, 1'b0, 1'b1);
    expect_out("sat_dn_clip", 1, 0, 1'b0, 1'b1, 1'b1);
    checkOutput();
    release_flags(1);
    pulse(1, 1'b0, 1'b1);
    expect_out("sat_dn_at_min", 1, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    release_flags(1);

    $display("[TB] debounce of four cycles");
    up[2] = 1'b1;
    tick(3);
    up[2] = 1'b0;
    tick(12);
    expect_out("deb_short_pulse", 2, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    up[2] = 1'b1;
    tick(5);
    up[2] = 1'b0;
    tick(1);
    expect_out("deb_edge6", 2, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    tick(1);
    expect_out("deb_edge7", 2, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick(15);
    expect_out("deb_settled", 2, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();

    $display("[TB] level mode, clamp and reset mid-hold");
    do_load(3, 20);
    expect_out("clamp_20", 3, 15, 1'b1, 1'b0, 1'b0);
    checkOutput();
    ld[0] = 1'b1; lv[0] = 5'd7;
    ld[3] = 1'b1; lv[3] = 5'd11;
    tick(1);
    ld[0] = 1'b0; ld[3] = 1'b0;
    up[0] = 1'b1; up[3] = 1'b1;
    tick(3);
    expect_out("lvl_edge3", 3, 11, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick(1);
    expect_out("lvl_edge4", 3, 12, 1'b0, 1'b0, 1'b0);
    checkOutput();
    expect_out("edge_a_edge4", 0, 8, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick(3);
    expect_out("lvl_edge7", 3, 15, 1'b1, 1'b0, 1'b0);
    checkOutput();
    tick(1);
    expect_out("lvl_plus5_wrap", 3, 0, 1'b0, 1'b1, 1'b1);
    checkOutput();
    expect_out("edge_a_held", 0, 8, 1'b0, 1'b0, 1'b0);
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst_mid_a", 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    expect_out("rst_mid_e", 3, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    tick(1);
    rst_n = 1'b1;
    tick(3);
    expect_out("post_rst_a_e3", 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    tick(1);
    expect_out("post_rst_a_e4", 0, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    expect_out("post_rst_e_e4", 3, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick(3);
    expect_out("post_rst_a_e7", 0, 1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    expect_out("post_rst_e_e7", 3, 4, 1'b0, 1'b0, 1'b0);
    checkOutput();
    up = '0;
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
